// File: rtl/branch_seq.sv
// Control sequencer for the conditional-branch instruction (CLR, COND, PCY, ADDS, WB, DONE).
// Optional per-outcome statistics counters when BRANCH_STATS_EN is defined.
module branch_seq #(
    parameter logic [4:0]  BR_OPCODE = 5'b10010,
    parameter int unsigned STAT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       IR,
    input  logic              CON_out,
    output logic              busy,
    output logic              done,
    output logic              taken,
    output logic              err,
    output logic              con_FF_Reset,
    output logic              Gra,
    output logic              Rout,
    output logic              CON_in,
    output logic              PCout,
    output logic              Yin,
    output logic              Cout,
    output logic              ADD,
    output logic              Zin,
    output logic              Zlowout,
    output logic              PCin
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] taken_cnt,
    output logic [STAT_W-1:0] not_taken_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        COND,
        PCY,
        ADDS,
        WB,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic   taken_q, taken_d;
    logic   err_q, err_d;

    // Only the opcode field steers the sequence; the condition bits feed the datapath.
    logic   unused_ir;
    assign unused_ir = ^IR[26:0];

    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (IR[31:27] == BR_OPCODE) state_d = CLR;
                    else                        err_d   = 1'b1;
                end
            end
            CLR:  state_d = COND;
            COND: state_d = PCY;
            PCY: begin
                taken_d = CON_out;
                state_d = CON_out ? ADDS : DONE;
            end
            ADDS: state_d = WB;
            WB:   state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
            err_q   <= err_d;
        end
    end

    // Strobes come from the registered state; reset masks them so nothing overlaps con_FF_Reset.
    always_comb begin
        Gra     = 1'b0;
        Rout    = 1'b0;
        CON_in  = 1'b0;
        PCout   = 1'b0;
        Yin     = 1'b0;
        Cout    = 1'b0;
        ADD     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        PCin    = 1'b0;
        done    = 1'b0;
        if (!reset) begin
            case (state_q)
                COND: begin
                    Gra    = 1'b1;
                    Rout   = 1'b1;
                    CON_in = 1'b1;
                end
                PCY: begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end
                ADDS: begin
                    Cout = 1'b1;
                    ADD  = 1'b1;
                    Zin  = 1'b1;
                end
                WB: begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
                DONE:    done = 1'b1;
                default: ;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign taken        = taken_q;
    assign err          = err_q && !reset;
    assign con_FF_Reset = reset || (state_q == CLR);

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [STAT_W-1:0] not_taken_cnt_q, not_taken_cnt_d;

    always_comb begin
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;
        if (state_q == PCY) begin
            if (CON_out) begin
                if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + STAT_W'(1);
            end else begin
                if (not_taken_cnt_q != '1) not_taken_cnt_d = not_taken_cnt_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else begin
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_seq.sv
// Randomized self-checking bench for branch_seq against a step-list reference model.
module tb_branch_seq;

    localparam int unsigned TB_STAT_W = 2;
    localparam logic [4:0]  BR_OPC    = 5'b10010;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] IR    = '0;
    logic        CON_out = 1'b0;
    logic busy, done, taken, err, con_FF_Reset, Gra, Rout, CON_in;
    logic PCout, Yin, Cout, ADD, Zin, Zlowout, PCin;
`ifdef BRANCH_STATS_EN
    logic [TB_STAT_W-1:0] taken_cnt, not_taken_cnt;
`endif

    branch_seq #(.BR_OPCODE(BR_OPC), .STAT_W(TB_STAT_W)) dut (
        .clock(clock), .reset(reset), .start(start), .IR(IR), .CON_out(CON_out),
        .busy(busy), .done(done), .taken(taken), .err(err), .con_FF_Reset(con_FF_Reset),
        .Gra(Gra), .Rout(Rout), .CON_in(CON_in), .PCout(PCout), .Yin(Yin),
        .Cout(Cout), .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin)
`ifdef BRANCH_STATS_EN
        , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the current step name plus the steps still planned for this branch.
    string       cur = "IDLE";
    string       plan[$];
    bit          m_taken = 1'b0;
    bit          m_err   = 1'b0;
    int unsigned m_tcnt  = 0;
    int unsigned m_ncnt  = 0;
    int unsigned stat_max = (1 << TB_STAT_W) - 1;

    // {busy,done,taken,err,con_FF_Reset,Gra,Rout,CON_in,PCout,Yin,Cout,ADD,Zin,Zlowout,PCin}
    function automatic logic [14:0] expected_outputs(string step, bit rst, bit tk, bit er);
        logic [14:0] v;
        v = '0;
        v[12] = tk;
        if (rst) begin
            v[10] = 1'b1;
            return v;
        end
        v[11] = er;
        if (step != "IDLE") v[14] = 1'b1;
        if (step == "CLR")  v[10] = 1'b1;
        if (step == "COND") v[9:7] = 3'b111;
        if (step == "PCY")  v[6:5] = 2'b11;
        if (step == "ADDS") v[4:2] = 3'b111;
        if (step == "WB")   v[1:0] = 2'b11;
        if (step == "DONE") v[13] = 1'b1;
        return v;
    endfunction

    task automatic model_edge(input bit rst, input bit st, input logic [31:0] ir, input bit con);
        if (rst) begin
            plan.delete();
            cur     = "IDLE";
            m_taken = 1'b0;
            m_err   = 1'b0;
            m_tcnt  = 0;
            m_ncnt  = 0;
            return;
        end
        m_err = 1'b0;
        if (cur == "IDLE") begin
            if (st && ir[31:27] == BR_OPC) begin
                plan.push_back("CLR");
                plan.push_back("COND");
                plan.push_back("PCY");
            end else if (st) begin
                m_err = 1'b1;
            end
        end else if (cur == "PCY") begin
            m_taken = con;
            if (con) begin
                if (m_tcnt < stat_max) m_tcnt++;
                plan.push_back("ADDS");
                plan.push_back("WB");
            end else begin
                if (m_ncnt < stat_max) m_ncnt++;
            end
            plan.push_back("DONE");
        end
        cur = (plan.size() > 0) ? plan.pop_front() : "IDLE";
    endtask

    task automatic cycle(input bit rst, input bit st, input logic [31:0] ir, input bit con);
        logic [14:0] obs;
        int unsigned groups;
        @(negedge clock);
        reset = rst; start = st; IR = ir; CON_out = con;
        @(posedge clock);
        model_edge(rst, st, ir, con);
        #1;
        obs = {busy, done, taken, err, con_FF_Reset, Gra, Rout, CON_in,
               PCout, Yin, Cout, ADD, Zin, Zlowout, PCin};
        check_eq({"outputs@", cur}, 32'(obs), 32'(expected_outputs(cur, rst, m_taken, m_err)));
        groups = int'(con_FF_Reset) + int'(Gra | Rout | CON_in) + int'(PCout | Yin)
               + int'(Cout | ADD | Zin) + int'(Zlowout | PCin);
        check_eq("one_group", 32'(groups <= 1), 32'd1);
`ifdef BRANCH_STATS_EN
        check_eq("taken_cnt", 32'(taken_cnt), m_tcnt);
        check_eq("not_taken_cnt", 32'(not_taken_cnt), m_ncnt);
`endif
    endtask

    initial begin
        logic [31:0] ir_r;
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h9000_0000, 1);

        // Taken branch, then not-taken, then a non-branch opcode.
        cycle(0, 1, 32'h9000_0000, 1);
        for (int i = 0; i < 7; i++) cycle(0, 0, 32'h9000_0000, 1);
        cycle(0, 1, 32'h9000_0000, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 32'h9000_0000, 0);
        cycle(0, 1, 32'h1800_0000, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 32'h1800_0000, 1);

        // Reset landing while in ADDS, with IR changing mid-flight.
        cycle(0, 1, 32'h9000_0000, 1);
        cycle(0, 0, 32'h1800_0000, 1);
        cycle(0, 1, 32'h0000_0000, 1);
        cycle(0, 0, 32'h9000_0000, 1);
        cycle(1, 1, 32'h9000_0000, 1);
        cycle(1, 1, 32'h9000_0000, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 32'h9000_0000, 1);

        // start held high: back-to-back sequences.
        for (int i = 0; i < 20; i++) cycle(0, 1, 32'h9000_0000, 1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 32'h9000_0000, 1);

        // Five taken (counter saturates at width 2) and one not-taken.
        cycle(1, 0, 32'h0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 32'h9000_0000, 1);
            for (int i = 0; i < 6; i++) cycle(0, 0, 32'h9000_0000, 1);
        end
        cycle(0, 1, 32'h9000_0000, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 32'h9000_0000, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            ir_r = $urandom;
            if ($urandom_range(1, 0) == 1) ir_r[31:27] = BR_OPC;
            cycle($urandom_range(49, 0) == 0, $urandom_range(1, 0) == 1, ir_r,
                  $urandom_range(1, 0) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 Parameter BR_OPCODE, default 5'b10010, is the IR[31:27] value identifying a conditional branch.
REQ-002 Parameter STAT_W, default 16, is the width of each statistics counter.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request to sequence the instruction held in IR; sampled only in IDLE.
REQ-006 IR  input  32  current instruction; opcode in IR[31:27], condition in IR[20:19].
REQ-007 CON_out  input  1  branch-condition flip-flop output.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 taken  output  1  branch-outcome flag; holds its value until the next accepted start.
REQ-011 err  output  1  one-cycle pulse when start is sampled with a non-branch opcode.
REQ-012 con_FF_Reset  output  1  clears the condition flip-flop.
REQ-013 Gra, Rout, CON_in  output  1 each  T3 strobes: select Ra, drive the bus, load the condition flip-flop.
REQ-014 PCout, Yin  output  1 each  T4 strobes.
REQ-015 Cout, ADD, Zin  output  1 each  T5 strobes: drive C-sign-extended, ALU add, load Z.
REQ-016 Zlowout, PCin  output  1 each  T6 strobes.
REQ-017 taken_cnt, not_taken_cnt  output  STAT_W each  present only with BRANCH_STATS_EN.

Function
REQ-018 The FSM states SHALL be IDLE, CLR, COND, PCY, ADDS, WB and DONE, encoded in a registered state variable.
REQ-019 All strobes SHALL be decoded from the registered state only (Moore); no strobe depends combinationally on start or CON_out.
REQ-020 IDLE + start + IR[31:27]==BR_OPCODE -> CLR; IDLE + start + other opcode -> IDLE with err high for exactly one cycle.
REQ-021 CLR SHALL assert con_FF_Reset and then go to COND.
REQ-022 COND SHALL assert Gra, Rout and CON_in and then go to PCY.
REQ-023 PCY SHALL assert PCout and Yin; the FSM samples CON_out at the end of PCY: 1 -> ADDS with taken<=1, 0 -> DONE with taken<=0.
REQ-024 ADDS SHALL assert Cout, ADD and Zin, then go to WB.
REQ-025 WB SHALL assert Zlowout and PCin, then go to DONE.
REQ-026 DONE SHALL assert done for one cycle and return to IDLE; start is ignored in DONE.
REQ-027 Latency from the start-sampling edge: taken -> done high in the 6th cycle; not taken -> done high in the 4th cycle.
REQ-028 At most one of the groups {con_FF_Reset}, {T3}, {T4}, {T5}, {T6} SHALL be active in any cycle.
REQ-029 start asserted while busy SHALL be ignored, with no queuing.
REQ-030 A change to IR while busy SHALL NOT alter the sequence; the opcode check happens only at acceptance.

Reset
REQ-031 With reset high, the next edge SHALL force IDLE, taken=0 and all strobes, done and err to 0, and SHALL assert con_FF_Reset combinationally while reset is high.
REQ-032 Reset SHALL override start and any in-flight state, including mid-sequence (e.g. in ADDS, with no PCin pulse afterwards).

Configuration
REQ-033 With BRANCH_STATS_EN defined, taken_cnt and not_taken_cnt SHALL increment at the PCY decision edge, saturate at all-ones, and clear on reset.
REQ-034 Without BRANCH_STATS_EN, those ports and their counters SHALL be absent, and all other behaviour is identical.

Verification
REQ-035 IR=32'h9000_0000 (opcode 10010), start pulse, CON_out=1 from COND onward -> CLR, COND, PCY, ADDS, WB, DONE; done in the 6th cycle; taken=1; PCin high exactly one cycle.
REQ-036 Same IR, CON_out=0 -> CLR, COND, PCY, DONE; done in the 4th cycle; taken=0; Cout, Zin and PCin never high.
REQ-037 IR=32'h1800_0000 (opcode 00011), start -> err one cycle, busy stays 0, no strobes.
REQ-038 reset raised during ADDS -> next cycle IDLE, all strobes 0, con_FF_Reset=1 while reset held, no PCin pulse afterwards.
REQ-039 start held high continuously for 20 cycles, CON_out=1 -> back-to-back sequences with exactly one IDLE cycle between DONE and the next CLR; no strobe overlap.
REQ-040 With BRANCH_STATS_EN and STAT_W=2: 5 taken branches -> taken_cnt=3 (saturated); 1 not-taken branch -> not_taken_cnt=1.
